point_subtractor: RTL and testbench

//  Sequential ECC point subtractor over GF(2^7): diff = P1 - P2 = P1 + (-P2), where -(x,y) = (x, x^y).

---
 rtl/ecc_gf7_pkg.sv | 54 +++++
 rtl/mastrovito7.sv | 29 ++
 rtl/point_subtractor.sv | 231 +++++++++++++++++++++++
 tb/tb_point_subtractor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_gf7_pkg.sv
// ---------------------------------------------------------------------------
// ecc_gf7_pkg
//   Shared definitions for the GF(2^7) ECC point arithmetic blocks:
//   field size, reduction polynomial, curve coefficient a, the point
//   subtractor FSM state encoding and operand case classification, plus
//   reduction and squaring helpers. Squaring is purely linear, so it does
//   not need the shared multiplier.
// ---------------------------------------------------------------------------
package ecc_gf7_pkg;

  localparam int         M        = 7;
  localparam logic [M:0] POLY     = 8'h83;        // x^7 + x + 1
  localparam logic [M-1:0] CURVE_A = 7'h01;       // y^2 + xy = x^3 + a*x^2 + b

  // The inverse is computed as d^126: five square-and-multiply steps
  // followed by one plain squaring, so the counter runs 0..5.
  localparam logic [2:0] INV_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_SLOPE,
    S_X3,
    S_Y3,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_ADD,
    C_DBL,
    C_ZERO,
    C_P1INF,
    C_P2INF
  } case_e;

  // Reduce a raw 13-bit polynomial product modulo POLY, top bit first.
  function automatic logic [M-1:0] gf_reduce(input logic [2*M-2:0] p);
    logic [2*M-2:0] t;
    t = p;
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) t = t ^ ({{(M-2){1'b0}}, POLY} << (i - M));
    end
    return t[M-1:0];
  endfunction

  // Squaring in characteristic 2 just spreads the bits to even positions.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    return gf_reduce(s);
  endfunction

endpackage

// File: rtl/mastrovito7.sv
// ---------------------------------------------------------------------------
// mastrovito7
//   Bit-parallel combinational GF(2^7) multiplier, p = a * b mod POLY.
//   Ports:
//     a_i  [6:0]  multiplicand
//     b_i  [6:0]  multiplier
//     p_o  [6:0]  reduced product
// ---------------------------------------------------------------------------
module mastrovito7
  import ecc_gf7_pkg::*;
(
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] p_o
);

  logic [2*M-2:0] prod;

  // NOTE: every variable assigned in always_comb gets a value before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    prod = '0;
    for (int i = 0; i < M; i++) begin
      if (b_i[i]) prod = prod ^ ({{(M-1){1'b0}}, a_i} << i);
    end
    p_o = gf_reduce(prod);
  end

endmodule

// File: rtl/point_subtractor.sv
// ---------------------------------------------------------------------------
// point_subtractor
//   Sequential ECC point subtraction over GF(2^7), diff = P1 + (-P2) with
//   -(x,y) = (x, x^y), on y^2 + xy = x^3 + x^2 + b. Infinity operands,
//   P1 == P2 and P1 == -P2 (doubling) are all handled. Every request takes
//   the same schedule (IDLE -> INV x6 -> SLOPE -> X3 -> Y3 -> DONE), and
//   done rises on the 10th rising edge after the accepting edge.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     start     request, sampled only in IDLE
//     point1    P1 = {y1, x1}
//     point2    P2 = {y2, x2}
//     p1_inf    P1 is the point at infinity
//     p2_inf    P2 is the point at infinity
//     busy      operation in progress
//     done      one-cycle pulse, result valid from this cycle
//     diff      result {y3, x3}, 0 when diff_inf is set
//     diff_inf  result is the point at infinity
// ---------------------------------------------------------------------------
module point_subtractor
  import ecc_gf7_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*M-1:0] point1,
  input  logic [2*M-1:0] point2,
  input  logic           p1_inf,
  input  logic           p2_inf,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] diff,
  output logic           diff_inf
);

  // Control and operand registers.
  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  case_e          kind_q, kind_d;
  logic           p1_inf_q, p1_inf_d;
  logic [M-1:0]   x1_q, x1_d, y1_q, y1_d;
  logic [M-1:0]   x2_q, x2_d, qy_q, qy_d;    // Q = -P2 = (x2, x2^y2)
  logic [M-1:0]   d_q, d_d, n_q, n_d;        // slope denominator / numerator

  // Datapath registers.
  logic [M-1:0]   r_q, r_d, lam_q, lam_d, x3_q, x3_d, y3_q, y3_d;

  // Output registers.
  logic [2*M-1:0] diff_q, diff_d;
  logic           diff_inf_q, diff_inf_d;
  logic           done_q, done_d;

  // Operand view of the request inputs.
  logic [M-1:0]   in_x1, in_y1, in_x2, in_y2, in_qy;
  case_e          in_kind;

  // Shared multiplier operands.
  logic [M-1:0]   mul_a, mul_b, mul_p;

  mastrovito7 u_mult (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign in_x1 = point1[M-1:0];
  assign in_y1 = point1[2*M-1:M];
  assign in_x2 = point2[M-1:0];
  assign in_y2 = point2[2*M-1:M];
  assign in_qy = in_x2 ^ in_y2;

  // Case priority: infinity operands first, then equal / negated x match.
  always_comb begin
    if (p2_inf)                                     in_kind = C_P2INF;
    else if (p1_inf)                                in_kind = C_P1INF;
    else if (in_x1 == in_x2 && in_y1 == in_y2)      in_kind = C_ZERO;
    else if (in_x1 == in_x2 && in_y1 == in_qy)      in_kind = C_DBL;
    else                                            in_kind = C_ADD;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    p1_inf_d   = p1_inf_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x2_d       = x2_q;
    qy_d       = qy_q;
    d_d        = d_q;
    n_d        = n_q;
    r_d        = r_q;
    lam_d      = lam_q;
    x3_d       = x3_q;
    y3_d       = y3_q;
    diff_d     = diff_q;
    diff_inf_d = diff_inf_q;
    done_d     = 1'b0;
    mul_a      = gf_sq(r_q);
    mul_b      = d_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INV;
          cnt_d    = '0;
          kind_d   = in_kind;
          p1_inf_d = p1_inf;
          x1_d     = in_x1;
          y1_d     = in_y1;
          x2_d     = in_x2;
          qy_d     = in_qy;
          d_d      = (in_kind == C_ADD) ? (in_x1 ^ in_x2) : in_x1;
          n_d      = (in_kind == C_ADD) ? (in_y1 ^ in_qy) : in_y1;
          r_d      = (in_kind == C_ADD) ? (in_x1 ^ in_x2) : in_x1;
        end
      end

      // r runs through d^3, d^7, d^15, d^31, d^63 and finally d^126 = 1/d.
      S_INV: begin
        if (cnt_q == INV_LAST) begin
          r_d     = gf_sq(r_q);
          state_d = S_SLOPE;
        end else begin
          r_d   = mul_p;
          cnt_d = cnt_q + 3'd1;
        end
      end

      // ADD: lam = n/d. Doubling: lam = x1 + y1/x1 (n = y1 there).
      S_SLOPE: begin
        mul_a   = r_q;
        mul_b   = n_q;
        lam_d   = mul_p ^ ((kind_q == C_ADD) ? '0 : x1_q);
        state_d = S_X3;
      end

      // x1 ^ x2 vanishes for doubling, so one form covers both cases.
      S_X3: begin
        x3_d    = gf_sq(lam_q) ^ lam_q ^ x1_q ^ x2_q ^ CURVE_A;
        state_d = S_Y3;
      end

      S_Y3: begin
        mul_a   = lam_q;
        mul_b   = x1_q ^ x3_q;
        y3_d    = mul_p ^ x3_q ^ y1_q;
        state_d = S_DONE;
      end

      // Special cases ran the full schedule; their result is chosen here.
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        unique case (kind_q)
          C_P2INF: begin
            diff_d     = p1_inf_q ? '0 : {y1_q, x1_q};
            diff_inf_d = p1_inf_q;
          end
          C_P1INF: begin
            diff_d     = {qy_q, x2_q};
            diff_inf_d = 1'b0;
          end
          C_ZERO: begin
            diff_d     = '0;
            diff_inf_d = 1'b1;
          end
          C_DBL: begin
            diff_d     = (x1_q == '0) ? '0 : {y3_q, x3_q};
            diff_inf_d = (x1_q == '0);
          end
          default: begin
            diff_d     = {y3_q, x3_q};
            diff_inf_d = 1'b0;
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kind_q     <= C_ADD;
      p1_inf_q   <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      qy_q       <= '0;
      d_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      lam_q      <= '0;
      x3_q       <= '0;
      y3_q       <= '0;
      diff_q     <= '0;
      diff_inf_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      p1_inf_q   <= p1_inf_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x2_q       <= x2_d;
      qy_q       <= qy_d;
      d_q        <= d_d;
      n_q        <= n_d;
      r_q        <= r_d;
      lam_q      <= lam_d;
      x3_q       <= x3_d;
      y3_q       <= y3_d;
      diff_q     <= diff_d;
      diff_inf_q <= diff_inf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign diff     = diff_q;
  assign diff_inf = diff_inf_q;

endmodule

// File: tb/tb_point_subtractor.sv
// ---------------------------------------------------------------------------
// tb_point_subtractor
//   Scoreboard bench for point_subtractor. Expected results come from an
//   independent affine-coordinate model (shift-and-add multiply, brute-force
//   inverse) and are queued when a request is issued; each done pops one
//   entry and compares result, infinity flag and latency.
// ---------------------------------------------------------------------------
module tb_point_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] point1, point2;
  logic        p1_inf, p2_inf;
  logic        busy, done, diff_inf;
  logic [13:0] diff;

  typedef struct {
    logic [13:0] diff;
    logic        inf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;

  point_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .point1   (point1),
    .point2   (point2),
    .p1_inf   (p1_inf),
    .p2_inf   (p2_inf),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .diff_inf (diff_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- golden model ----------------
  function automatic logic [6:0] gmul(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r = r ^ t;
      t = t[6] ? ({t[5:0], 1'b0} ^ 7'h03) : {t[5:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [6:0] ginv(input logic [6:0] a);
    logic [6:0] c;
    for (int k = 1; k < 128; k++) begin
      c = 7'(k);
      if (gmul(a, c) == 7'h01) return c;
    end
    return 7'h00;
  endfunction

  // Returns {inf, y3, x3} for P1 - P2.
  function automatic logic [14:0] model(input logic [13:0] p1, input logic [13:0] p2,
                                        input logic i1, input logic i2);
    logic [6:0] x1, y1, qx, qy, lam, x3, y3;
    x1 = p1[6:0];
    y1 = p1[13:7];
    qx = p2[6:0];
    qy = p2[6:0] ^ p2[13:7];
    if (i2) return i1 ? {1'b1, 14'h0} : {1'b0, p1};
    if (i1) return {1'b0, qy, qx};
    if (x1 == qx) begin
      if (y1 != qy || x1 == 7'h00) return {1'b1, 14'h0};
      lam = x1 ^ gmul(y1, ginv(x1));
      x3  = gmul(lam, lam) ^ lam ^ 7'h01;
      y3  = gmul(x1, x1) ^ gmul(lam ^ 7'h01, x3);
    end else begin
      lam = gmul(y1 ^ qy, ginv(x1 ^ qx));
      x3  = gmul(lam, lam) ^ lam ^ x1 ^ qx ^ 7'h01;
      y3  = gmul(lam, x1 ^ x3) ^ x3 ^ y1;
    end
    return {1'b0, y3, x3};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("diff",     32'(diff),     32'(mon_e.diff));
        check("diff_inf", 32'(diff_inf), 32'(mon_e.inf));
        check("latency",  32'(edge_cnt - mon_e.acc), 32'd10);
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Call right after a falling edge; the request is taken at the next rise.
  task automatic issue(input logic [13:0] p1, input logic [13:0] p2,
                       input logic i1, input logic i2);
    logic [14:0] m;
    exp_t e;
    point1 = p1;
    point2 = p2;
    p1_inf = i1;
    p2_inf = i2;
    start  = 1'b1;
    m      = model(p1, p2, i1, i2);
    e.diff = m[13:0];
    e.inf  = m[14];
    e.acc  = edge_cnt + 1;
    sb.push_back(e);
  endtask

  // Drop start and scramble operands; the DUT must have latched them.
  task automatic release_start();
    @(negedge clk);
    start  = 1'b0;
    point1 = 14'($urandom);
    point2 = 14'($urandom);
    p1_inf = 1'($urandom);
    p2_inf = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] x1, x2, y1, y2;
    int dc;

    rst_n  = 1'b0;
    start  = 1'b0;
    point1 = '0;
    point2 = '0;
    p1_inf = 1'b0;
    p2_inf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_diff",     32'(diff),     32'd0);
    check("rst_diff_inf", 32'(diff_inf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Generic additions with x1 != x2.
    for (int k = 0; k < 8; k++) begin
      x2 = 7'($urandom_range(0, 127));
      y1 = 7'($urandom_range(0, 127));
      y2 = 7'($urandom_range(0, 127));
      do x1 = 7'($urandom_range(0, 127)); while (x1 == x2);
      issue({y1, x1}, {y2, x2}, 1'b0, 1'b0);
      release_start();
      check("busy_during_op", 32'(busy), 32'd1);
      drain();
    end

    // P1 == P2 -> infinity.
    issue(14'h0A05, 14'h0A05, 1'b0, 1'b0);
    release_start();
    drain();

    // Infinity operands.
    issue(14'h1234, 14'h0000, 1'b0, 1'b1);
    release_start();
    drain();
    issue(14'h0000, {7'h10, 7'h05}, 1'b1, 1'b0);
    release_start();
    drain();
    issue(14'h1111, 14'h2222, 1'b1, 1'b1);
    release_start();
    drain();

    // Doubling: P1 == -P2.
    issue({7'h15, 7'h05}, {7'h10, 7'h05}, 1'b0, 1'b0);
    release_start();
    drain();
    // x = 0 corner.
    issue({7'h01, 7'h00}, {7'h01, 7'h00}, 1'b0, 1'b0);
    release_start();
    drain();

    // Result is held between operations.
    issue({7'h33, 7'h21}, {7'h4C, 7'h07}, 1'b0, 1'b0);
    release_start();
    drain();
    repeat (5) @(negedge clk);
    check("diff_hold", 32'(diff), 32'(model({7'h33, 7'h21}, {7'h4C, 7'h07}, 1'b0, 1'b0)));

    // Stray starts while busy are ignored.
    dc = done_cnt;
    issue({7'h2A, 7'h11}, {7'h05, 7'h62}, 1'b0, 1'b0);
    release_start();
    @(negedge clk);
    point1 = 14'h3FFF; point2 = 14'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    point1 = 14'h0ABC; point2 = 14'h1DEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("one_done_with_strays", 32'(done_cnt - dc), 32'd1);

    // Back-to-back: new start presented in the done cycle.
    dc = done_cnt;
    issue({7'h0F, 7'h40}, {7'h70, 7'h03}, 1'b0, 1'b0);
    release_start();
    for (int g = 0; g < 20 && !done; g++) @(negedge clk);
    check("b2b_first_done_seen", 32'(done), 32'd1);
    issue({7'h5A, 7'h1C}, {7'h26, 7'h7E}, 1'b0, 1'b0);
    release_start();
    drain();
    check("b2b_two_dones", 32'(done_cnt - dc), 32'd2);

    // Reset in the middle of an operation.
    issue({7'h6B, 7'h39}, {7'h12, 7'h44}, 1'b0, 1'b0);
    release_start();
    repeat (4) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    dc    = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_done",     32'(done),     32'd0);
    check("midrst_diff",     32'(diff),     32'd0);
    check("midrst_diff_inf", 32'(diff_inf), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt - dc), 32'd0);

    // Recovery after reset.
    issue({7'h01, 7'h7F}, {7'h02, 7'h03}, 1'b0, 1'b0);
    release_start();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
